// File: rtl/resp_tx_pkg.sv
// Shared types and constants for the slave-to-master response transmitter.
// No logic of its own; latency and backpressure are defined by resp_tx.
// Optional checksum byte is enabled with RESP_TX_CHECKSUM_EN.
package resp_tx_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_SOF     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAY     = 3'd3,
    ST_CSUM    = 3'd4
  } state_e;

  localparam byte_t SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/resp_tx_if.sv
// Valid/ready link bundle between the slave datapath, the transmitter and the master.
// Pure wiring, zero latency.
// The master drives ready; the transmitter holds valid/data_out while ready is low.
interface resp_tx_if;
  import resp_tx_pkg::*;

  byte_t data_in;
  logic  data_en;
  logic  pkt_end;
  logic  ready;
  logic  valid;
  byte_t data_out;
  logic  busy;
  logic  overflow;

  modport slave (
    input  data_in, data_en, pkt_end, ready,
    output valid, data_out, busy, overflow
  );

  modport master (
    output data_in, data_en, pkt_end, ready,
    input  valid, data_out, busy, overflow
  );

endinterface

// File: rtl/resp_tx_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, combinational read.
// Write visible one cycle after wr_en; read is same-cycle.
// No backpressure; the caller gates wr_en.
module resp_tx_buf
  import resp_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  byte_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output byte_t         rd_data
);

  byte_t mem [DEPTH];

  // Contents need no reset: the byte count is what defines valid entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/resp_tx.sv
// Collects payload bytes, then frames SOF, LEN, payload (and XOR checksum with RESP_TX_CHECKSUM_EN).
// First frame byte is valid the cycle after the pkt_end edge; one byte per cycle with ready high.
// valid/data_out held while ready is low; writes arriving outside collection are dropped and flagged.
module resp_tx
  import resp_tx_pkg::*;
#(
  parameter int    DEPTH = 16,
  parameter byte_t SOF   = SOF_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  resp_tx_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [2:0] S_COLLECT = 3'(ST_COLLECT);
  localparam logic [2:0] S_SOF     = 3'(ST_SOF);
  localparam logic [2:0] S_LEN     = 3'(ST_LEN);
  localparam logic [2:0] S_PAY     = 3'(ST_PAY);
`ifdef RESP_TX_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'(ST_CSUM);
`endif

  logic [2:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] rd_ptr;
  logic          valid_q;
  byte_t         dout_q;
  logic          ovf_q;
  byte_t         rd_data;
  logic          wr_en;
  logic          drop;
  logic          hs;
  logic [CW-1:0] eff_count;
`ifdef RESP_TX_CHECKSUM_EN
  byte_t         csum;
`endif

  assign wr_en     = bus.data_en && (state == S_COLLECT) && (count != FULL);
  assign drop      = bus.data_en && !wr_en;
  assign eff_count = count + CW'(wr_en);
  assign hs        = valid_q && bus.ready;

  resp_tx_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  // rd_ptr always points at the next payload byte to load into dout_q,
  // so the last payload byte is on the wire once rd_ptr reaches count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_COLLECT;
      count   <= '0;
      rd_ptr  <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef RESP_TX_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end
      case (state)
        S_COLLECT: begin
          count <= eff_count;
          if (bus.pkt_end && (eff_count != '0)) begin
            state   <= S_SOF;
            valid_q <= 1'b1;
            dout_q  <= SOF;
          end
        end
        S_SOF: begin
          if (hs) begin
            state  <= S_LEN;
            dout_q <= byte_t'(count);
`ifdef RESP_TX_CHECKSUM_EN
            csum   <= byte_t'(count);
`endif
          end
        end
        S_LEN: begin
          if (hs) begin
            state  <= S_PAY;
            dout_q <= rd_data;
            rd_ptr <= rd_ptr + ONE;
          end
        end
        S_PAY: begin
          if (hs) begin
`ifdef RESP_TX_CHECKSUM_EN
            csum <= csum ^ dout_q;
`endif
            if (rd_ptr == count) begin
`ifdef RESP_TX_CHECKSUM_EN
              state  <= S_CSUM;
              dout_q <= csum ^ dout_q;
`else
              state   <= S_COLLECT;
              valid_q <= 1'b0;
              dout_q  <= '0;
              count   <= '0;
              rd_ptr  <= '0;
`endif
            end else begin
              dout_q <= rd_data;
              rd_ptr <= rd_ptr + ONE;
            end
          end
        end
`ifdef RESP_TX_CHECKSUM_EN
        S_CSUM: begin
          if (hs) begin
            state   <= S_COLLECT;
            valid_q <= 1'b0;
            dout_q  <= '0;
            count   <= '0;
            rd_ptr  <= '0;
          end
        end
`endif
        default: begin
          state   <= S_COLLECT;
          valid_q <= 1'b0;
          count   <= '0;
          rd_ptr  <= '0;
        end
      endcase
    end
  end

  assign bus.valid    = valid_q;
  assign bus.data_out = dout_q;
  assign bus.busy     = (state != S_COLLECT);
  assign bus.overflow = ovf_q;

endmodule
